// File: rtl/washer_ctrl_param_if.sv
// Front-panel / driver bundle for the parametrised washer sequencer.
// master = panel/driver side, slave = controller.
interface washer_ctrl_param_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             cancel;
    logic             lid;
    logic [1:0]       mode;
    logic [2:0]       state;
    logic [1:0]       phase_sel;
    logic             soak_en;
    logic             wash_en;
    logic             rinse_en;
    logic             spin_en;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       rinse_cnt;
    logic             busy;
    logic             paused;
    logic             done;

    modport master (
        output start, cancel, lid, mode,
        input  state, phase_sel, soak_en, wash_en, rinse_en, spin_en,
               remaining, rinse_cnt, busy, paused, done
    );

    modport slave (
        input  start, cancel, lid, mode,
        output state, phase_sel, soak_en, wash_en, rinse_en, spin_en,
               remaining, rinse_cnt, busy, paused, done
    );
endinterface

// File: rtl/washer_ctrl_param.sv
// Parametrised washing-machine sequencer with internal phase timer,
// wash profiles, programmable rinse count and lid handling.
// Optional feature macro: WASHER_PAUSE_EN (lid open -> PAUSE, resume on start).
module washer_ctrl_param #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SOAK_CYC  = 100,
    parameter int unsigned WASH_CYC  = 200,
    parameter int unsigned RINSE_CYC = 80,
    parameter int unsigned SPIN_CYC  = 60,
    parameter int unsigned MAX_RINSE = 3
) (
    input  logic                clk,
    input  logic                rst,
    washer_ctrl_param_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_SOAK  = 3'd2,
        S_WASH  = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_PAUSE = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    localparam logic [1:0] M_NONE   = 2'd0;
    localparam logic [1:0] M_QUICK  = 2'd1;
    localparam logic [1:0] M_NORMAL = 2'd2;
    localparam logic [1:0] M_HEAVY  = 2'd3;

    localparam int unsigned WASH_HEAVY_CYC = 2 * WASH_CYC;
    localparam int unsigned NORMAL_RINSE   = (MAX_RINSE < 2) ? MAX_RINSE : 2;

    localparam logic [CNT_W-1:0] SOAK_LD       = CNT_W'(SOAK_CYC - 1);
    localparam logic [CNT_W-1:0] WASH_LD       = CNT_W'(WASH_CYC - 1);
    localparam logic [CNT_W-1:0] WASH_HEAVY_LD = CNT_W'(WASH_HEAVY_CYC - 1);
    localparam logic [CNT_W-1:0] RINSE_LD      = CNT_W'(RINSE_CYC - 1);
    localparam logic [CNT_W-1:0] SPIN_LD       = CNT_W'(SPIN_CYC - 1);
    localparam logic [2:0]       RINSE_NORMAL  = 3'(NORMAL_RINSE);
    localparam logic [2:0]       RINSE_HEAVY   = 3'(MAX_RINSE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rinse_q, rinse_d;
    logic [1:0]       prof_q, prof_d;
    logic [2:0]       rinse_target;
    logic [2:0]       rinse_inc;

    logic [1:0]       phase_sel_q, phase_sel_d;
    logic [3:0]       en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef WASHER_PAUSE_EN
    state_e           saved_q, saved_d;
    logic             paused_q;
`endif

    // Rinse passes required by the latched profile
    always_comb begin
        rinse_target = 3'd1;
        case (prof_q)
            M_NORMAL: rinse_target = RINSE_NORMAL;
            M_HEAVY:  rinse_target = RINSE_HEAVY;
            default:  rinse_target = 3'd1;
        endcase
    end

    // Next-state, counter, rinse count and profile selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rinse_d   = rinse_q;
        prof_d    = prof_q;
        rinse_inc = rinse_q + 3'd1;
`ifdef WASHER_PAUSE_EN
        saved_d   = saved_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                rinse_d = '0;
                if (bus.start && !bus.lid && !bus.cancel) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (bus.mode != M_NONE && !bus.lid) begin
                    prof_d = bus.mode;
                    if (bus.mode == M_QUICK) begin
                        state_d = S_WASH;
                        cnt_d   = WASH_LD;
                    end else begin
                        state_d = S_SOAK;
                        cnt_d   = SOAK_LD;
                    end
                end
            end
            S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rinse_d = '0;
                end else if (bus.lid) begin
`ifdef WASHER_PAUSE_EN
                    state_d = S_PAUSE;
                    saved_d = state_q;
`endif
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        S_SOAK: begin
                            state_d = S_WASH;
                            cnt_d   = (prof_q == M_HEAVY) ? WASH_HEAVY_LD : WASH_LD;
                        end
                        S_WASH: begin
                            state_d = S_RINSE;
                            cnt_d   = RINSE_LD;
                        end
                        S_RINSE: begin
                            rinse_d = rinse_inc;
                            if (rinse_inc < rinse_target) begin
                                cnt_d = RINSE_LD;
                            end else begin
                                state_d = S_SPIN;
                                cnt_d   = SPIN_LD;
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            S_PAUSE: begin
`ifdef WASHER_PAUSE_EN
                if (bus.cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rinse_d = '0;
                end else if (bus.start && !bus.lid) begin
                    state_d = saved_q;
                end
`else
                state_d = S_IDLE;
                cnt_d   = '0;
                rinse_d = '0;
`endif
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rinse_d = '0;
            end
        endcase
    end

    // Output decode of the next state, registered alongside it
    always_comb begin
        phase_sel_d = 2'b00;
        en_d        = 4'b0000;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_SOAK:  begin phase_sel_d = 2'b00; en_d = 4'b1000; busy_d = 1'b1; end
            S_WASH:  begin phase_sel_d = 2'b01; en_d = 4'b0100; busy_d = 1'b1; end
            S_RINSE: begin phase_sel_d = 2'b10; en_d = 4'b0010; busy_d = 1'b1; end
            S_SPIN:  begin phase_sel_d = 2'b11; en_d = 4'b0001; busy_d = 1'b1; end
            S_PAUSE: busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State, counter and decoded output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rinse_q     <= '0;
            prof_q      <= M_QUICK;
            phase_sel_q <= 2'b00;
            en_q        <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rinse_q     <= rinse_d;
            prof_q      <= prof_d;
            phase_sel_q <= phase_sel_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef WASHER_PAUSE_EN
    // Phase to return to after a lid pause, and the paused flag
    always_ff @(posedge clk) begin
        if (rst) begin
            saved_q  <= S_IDLE;
            paused_q <= 1'b0;
        end else begin
            saved_q  <= saved_d;
            paused_q <= (state_d == S_PAUSE);
        end
    end

    assign bus.paused = paused_q;
`else
    assign bus.paused = 1'b0;
`endif

    assign bus.state     = state_q;
    assign bus.remaining = cnt_q;
    assign bus.rinse_cnt = rinse_q;
    assign bus.phase_sel = phase_sel_q;
    assign bus.soak_en   = en_q[3];
    assign bus.wash_en   = en_q[2];
    assign bus.rinse_en  = en_q[1];
    assign bus.spin_en   = en_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
